// File: rtl/f5_packer.sv
// f5_packer: packs a stream of F5 results into 256-bit words for the F5 feature RAM write port
module f5_packer #(
   parameter int DATA_W  = 16,
   parameter int LANES   = 16,
   parameter int ADDR_W  = 5,
   parameter int NUM_OUT = 120
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      in_valid,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      in_ready,
   output logic [ADDR_W-1:0]         f5_waddr,
   output logic [DATA_W*LANES-1:0]   f5_wdata,
   output logic                      f5_wr_en,
   output logic                      busy,
   output logic                      done
);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int EW = $clog2(NUM_OUT + 1);

   typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

   state_t                          r_state;
   logic [LANES-1:0][DATA_W-1:0]    r_buf;
   logic [LANES-1:0][DATA_W-1:0]    w_buf;
   logic [LW-1:0]                   r_lane;
   logic [EW-1:0]                   r_elem;
   logic [ADDR_W-1:0]               r_word;
   logic                            w_acc;
   logic                            w_last;
   logic                            w_flush;

   assign w_acc   = (r_state == PACK) && in_valid && in_ready;
   assign w_last  = r_elem == EW'(NUM_OUT - 1);
   assign w_flush = w_acc && (r_lane == LW'(LANES - 1) || w_last);

   // buffer as it looks with the current input merged into its lane
   always_comb begin
      w_buf         = r_buf;
      w_buf[r_lane] = in_data;
   end

   // frame FSM: lane packing, word flush strobes and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_buf    <= '0;
         r_lane   <= '0;
         r_elem   <= '0;
         r_word   <= '0;
         in_ready <= 1'b0;
         f5_waddr <= '0;
         f5_wdata <= '0;
         f5_wr_en <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         f5_wr_en <= 1'b0;
         done     <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_state  <= PACK;
               in_ready <= 1'b1;
               busy     <= 1'b1;
               r_buf    <= '0;
               r_lane   <= '0;
               r_elem   <= '0;
               r_word   <= '0;
            end
            PACK: if (w_acc) begin
               r_elem <= r_elem + 1'b1;
               r_lane <= w_flush ? '0 : r_lane + 1'b1;
               r_buf  <= w_flush ? '0 : w_buf;
               if (w_flush) begin
                  f5_wr_en <= 1'b1;
                  f5_waddr <= r_word;
                  f5_wdata <= w_buf;
                  r_word   <= r_word + 1'b1;
               end
               if (w_last) begin
                  in_ready <= 1'b0;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
